// File: rtl/seg7_scan_ctrl_if.sv
// Signal bundle between the value-producing application logic (master)
// and the seven-segment scan controller (slave).
interface seg7_scan_ctrl_if;
  logic        enable;
  logic        blank_lz;
  logic        load;
  logic [31:0] value;
  logic [3:0]  digit_bcd;
  logic [7:0]  anodes;
  logic        pending;
  logic        frame_start;

  modport master (
    output enable, blank_lz, load, value,
    input  digit_bcd, anodes, pending, frame_start
  );

  modport slave (
    input  enable, blank_lz, load, value,
    output digit_bcd, anodes, pending, frame_start
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit common-anode seven-segment scan controller. Walks the digits
// one slot at a time, feeds one nibble of the active value to the shared
// decoder and drives active-low anodes with a dead band at the start of
// each slot. New values are double-buffered and swap in only on a frame
// boundary so a frame never mixes two values.
module seg7_scan_ctrl #(
  parameter int unsigned COUNT_MAX   = 100000,
  parameter int unsigned DEAD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  seg7_scan_ctrl_if.slave    bus
);

  localparam int unsigned TW = (COUNT_MAX > 2) ? $clog2(COUNT_MAX) : 1;

  typedef enum logic [1:0] {
    PH_OFF,
    PH_BLANK,
    PH_DRIVE
  } phase_e;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    digit_idx_q, digit_idx_d;
  logic [31:0]   pend_val_q, pend_val_d;
  logic          pend_flag_q, pend_flag_d;
  logic [31:0]   act_val_q, act_val_d;
  // Registered copies of the mode inputs keep every output register-driven.
  logic          en_q;
  logic          blank_lz_q;

  logic          slot_end;
  logic          frame_end;
  logic          upper_zero;
  logic          digit_blank;
  phase_e        phase;

  assign slot_end  = (tick_cnt_q == TW'(COUNT_MAX - 1));
  assign frame_end = en_q && slot_end && (digit_idx_q == 3'd7);

  // Next-state: slot/digit counters plus the pending/active buffer swap.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    tick_cnt_d  = tick_cnt_q;
    digit_idx_d = digit_idx_q;
    pend_val_d  = pend_val_q;
    pend_flag_d = pend_flag_q;
    act_val_d   = act_val_q;

    if (!en_q) begin
      tick_cnt_d  = '0;
      digit_idx_d = '0;
    end else if (slot_end) begin
      tick_cnt_d  = '0;
      digit_idx_d = digit_idx_q + 3'd1;
    end else begin
      tick_cnt_d  = tick_cnt_q + TW'(1);
    end

    // Commit happens before the load so a load on the boundary edge waits
    // for the following boundary instead of tearing the current frame.
    if (pend_flag_q && (frame_end || !en_q)) begin
      act_val_d   = pend_val_q;
      pend_flag_d = 1'b0;
    end

    if (bus.load) begin
      pend_val_d  = bus.value;
      pend_flag_d = 1'b1;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      tick_cnt_q  <= '0;
      digit_idx_q <= '0;
      // NOTE: the 32-bit value buffers are plain flops here and are cleared so a reset shows a dark, all-zero display.
      pend_val_q  <= '0;
      pend_flag_q <= 1'b0;
      act_val_q   <= '0;
      en_q        <= 1'b0;
      blank_lz_q  <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      digit_idx_q <= digit_idx_d;
      pend_val_q  <= pend_val_d;
      pend_flag_q <= pend_flag_d;
      act_val_q   <= act_val_d;
      en_q        <= bus.enable;
      blank_lz_q  <= bus.blank_lz;
    end
  end

  // Slot phase decode: dark when off, dead band first, then drive.
  always_comb begin
    phase = PH_OFF;
    if (en_q) begin
      phase = (tick_cnt_q >= TW'(DEAD_CYCLES)) ? PH_DRIVE : PH_BLANK;
    end
  end

  // A digit is a leading zero when it and every digit to its left are zero.
  assign upper_zero  = ((act_val_q >> {digit_idx_q, 2'b00}) == 32'd0);
  assign digit_blank = blank_lz_q && (digit_idx_q != 3'd0) && upper_zero;

  assign bus.digit_bcd   = act_val_q[{digit_idx_q, 2'b00} +: 4];
  assign bus.anodes      = ((phase == PH_DRIVE) && !digit_blank) ?
                           ~(8'b1 << digit_idx_q) : 8'hFF;
  assign bus.pending     = pend_flag_q;
  assign bus.frame_start = en_q && (digit_idx_q == 3'd0) && (tick_cnt_q == '0);

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing controller for the 8-digit common-anode seven-segment display: it shares the single combinational BCD/hex-to-seven-segment decoder between all eight digits by scanning them one at a time. It holds a double-buffered 32-bit display value, sends one nibble per scan slot to the decoder and drives the active-low anode lines. Dead time between slots prevents ghosting, and leading-zero blanking is optional. It sits between the application logic that produces values and the decoder/pin outputs at the top level.

## Interface
- COUNT_MAX, 100000: clock cycles per digit slot (≥ 2).
- DEAD_CYCLES, 4: cycles at the start of each slot with all anodes off (must be < COUNT_MAX).
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  1 = scan running; 0 = display dark.
- blank_lz  in  1  1 = suppress leading-zero digits.
- load  in  1  single-cycle strobe; captures value into the pending buffer.
- value  in  32  eight hex nibbles; nibble i = value[4i+3:4i] is shown on digit i, and digit 0 is the rightmost.
- digit_bcd  out  4  nibble for the current slot, fed to the decoder input.
- anodes  out  8  active-low digit enables; bit i drives digit i.
- pending  out  1  1 = a loaded value is waiting for the next frame boundary.
- frame_start  out  1  one-cycle pulse on the first cycle of each digit-0 slot.

## Operation
- Registers:
  - tick_cnt: 0..COUNT_MAX-1.
  - digit_idx: 0..7.
  - pend_val (32 bits) and pend_flag.
  - act_val (32 bits).
- All outputs are decoded from registers only. There is no combinational path from any input to any output.
- Reset values: tick_cnt=0, digit_idx=0, pend_val=0, pend_flag=0, act_val=0. Resulting outputs: anodes=8'hFF, digit_bcd=0, pending=0, frame_start=0.
- Per-cycle state (enable=1):
  - BLANK: tick_cnt < DEAD_CYCLES.
  - DRIVE: tick_cnt ≥ DEAD_CYCLES.
  - OFF: whenever enable=0.
- Slot advance:
  - tick_cnt increments each cycle.
  - At COUNT_MAX-1, tick_cnt wraps to 0 and digit_idx increments (7 wraps to 0).
- Frame boundary: the edge on which digit_idx goes 7→0.
  - If pend_flag=1: act_val ← pend_val and pend_flag ← 0.
  - The new value is therefore visible from the digit-0 slot onward. There is never a mixed (torn) frame.
- Load:
  - A load strobe sets pend_val ← value and pend_flag ← 1.
  - Repeated loads before a boundary overwrite the buffer; the latest value wins.
- Load on the boundary edge: the commit uses the old pend_val. The new value goes into pend_val with pend_flag=1 and commits at the next boundary.
- digit_bcd = act_val nibble digit_idx in every state, so the decoder input stays stable for the whole slot.
- anodes:
  - BLANK or OFF: 8'hFF.
  - DRIVE: bit digit_idx low, others high, unless the digit is blanked.
- Leading-zero blank: digit i > 0 is blanked (anodes held 8'hFF for its whole slot) when blank_lz=1 and act_val nibbles i..7 are all zero. Digit 0 is never blanked.
- enable=0 (OFF):
  - tick_cnt and digit_idx are forced to 0.
  - Loads are still accepted.
  - pend_flag commits to act_val on the next edge (no frame to protect).
- enable 0→1: scanning starts in the BLANK phase of digit 0, and frame_start pulses on that first cycle.
- Reset mid-frame: state returns to reset values immediately and a pending value is lost.

## Timing
- Slot length is COUNT_MAX cycles; frame length is 8·COUNT_MAX cycles.
- Refresh rate is f_clk/(8·COUNT_MAX). With the defaults at 100 MHz this is 125 Hz per frame.
- Within each slot: DEAD_CYCLES cycles with anodes=8'hFF, then COUNT_MAX-DEAD_CYCLES cycles driving one digit.
- frame_start is high exactly when enable=1, digit_idx=0 and tick_cnt=0.
- Load-to-display latency: at most one frame plus DEAD_CYCLES. Minimum is DEAD_CYCLES+1 cycles when load lands on the cycle before a boundary.
- pending rises on the cycle after load and falls on the cycle after the commit edge.

## Test plan
All scenarios use COUNT_MAX=8 and DEAD_CYCLES=2.

- Reset, then enable=1 and load value=32'h89ABCDEF -> committed at the first boundary. Over the next frame, digit_bcd runs F,E,D,C,B,A,9,8. Each slot shows 2 cycles of anodes=FF, then 6 cycles of one low bit: FE, FD, FB, … 7F. frame_start recurs every 64 cycles.
- Load 32'h11111111 at tick 3 of digit 2, then load 32'h22222222 at digit 5 -> pending=1 throughout. At the boundary act_val=22222222 and pending=0. The value 11111111 is never displayed.
- Load on the exact boundary edge while pending holds 32'h00000005, new value 32'h00000007 -> the next frame shows 5 and pending stays 1. The frame after shows 7.
- blank_lz=1 with act_val=32'h00000305 -> digits 0-2 are driven (nibbles 5, 0, 3). Digits 3-7 keep anodes=FF for their entire slots. With act_val=0, only digit 0 is lit, showing 0.
- enable=0 mid-frame, then load 32'h0000ABCD -> anodes=FF the next cycle and act_val=ABCD one cycle after pending rises. On enable=1, frame_start pulses immediately and digit 0 shows D.
- Assert reset at digit 4 with pending=1 -> anodes=FF, digit_bcd=0 and pending=0 asynchronously. After release, act_val=0.
